spif_cfg_reg_bank: RTL and testbench

Parametrised configuration and diagnostic register bank for the SpiNNaker peripheral interface; successor to the single-pipe HSSL register bank. It serves an APB slave port and a packet-side register port (packet reads and writes, with a response handshake) through one arbitrated access engine. It drives router, mapper, HSSL-control and wait-time registers, and maintains diagnostic counters. Out-of-range accesses are reported through `apb_pslverr_out`.

---
 rtl/spif_cfg_reg_bank.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_spif_cfg_reg_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spif_cfg_reg_bank.sv
// spif_cfg_reg_bank: APB + packet-port configuration and diagnostic register bank.
// Optional build macro SPIF_CTR_CLR_ON_RD_EN makes counter reads clear the counter.
module spif_cfg_reg_bank #(
    parameter int NUM_PIPES      = 1,
    parameter int NUM_MREGS_PIPE = 4,
    parameter int NUM_RREGS      = 16,
    parameter int NUM_CREGS      = 8,
    parameter int SEC_BITS       = 4,
    parameter int REG_BITS       = 4,
    parameter int RRTE_BITS      = 3,
    parameter int MSFT_BITS      = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         apb_psel_in,
    input  logic                         apb_penable_in,
    input  logic                         apb_pwrite_in,
    input  logic [39:0]                  apb_paddr_in,
    input  logic [31:0]                  apb_pwdata_in,
    output logic [31:0]                  apb_prdata_out,
    output logic                         apb_pready_out,
    output logic                         apb_pslverr_out,
    input  logic                         prx_req_in,
    input  logic                         prx_wr_in,
    input  logic [SEC_BITS+REG_BITS-1:0] prx_addr_in,
    input  logic [31:0]                  prx_wdata_in,
    output logic                         prx_rdy_out,
    output logic                         prx_rsp_vld_out,
    output logic [31:0]                  prx_rsp_data_out,
    input  logic                         prx_rsp_rdy_in,
    input  logic [NUM_CREGS-1:0]         ctr_cnt_in,
    input  logic [31:0]                  status_in,
    input  logic [31:0]                  hw_version_in,
    output logic                         hssl_stop_out,
    output logic [31:0]                  reply_key_out,
    output logic [31:0]                  input_wait_out,
    output logic [31:0]                  output_wait_out,
    output logic [31:0]                  rt_key_out   [NUM_RREGS],
    output logic [31:0]                  rt_mask_out  [NUM_RREGS],
    output logic [RRTE_BITS-1:0]         rt_route_out [NUM_RREGS],
    output logic [31:0]                  mp_key_out   [NUM_PIPES],
    output logic [31:0]                  mp_fmsk_out  [NUM_PIPES*NUM_MREGS_PIPE],
    output logic [MSFT_BITS-1:0]         mp_fsft_out  [NUM_PIPES*NUM_MREGS_PIPE],
    output logic [31:0]                  ctr_out      [NUM_CREGS]
);
    localparam int NUM_MREGS = NUM_PIPES * NUM_MREGS_PIPE;
    localparam logic [31:0] N_RREGS_W = NUM_RREGS;
    localparam logic [31:0] N_CREGS_W = NUM_CREGS;
    localparam logic [31:0] N_PIPES_W = NUM_PIPES;
    localparam logic [31:0] N_MREGS_W = NUM_MREGS;
    localparam logic [31:0] BAD_DATA  = 32'hdead_0bad;

    localparam logic [SEC_BITS-1:0] SEC_CTRL = SEC_BITS'(32'd0);
    localparam logic [SEC_BITS-1:0] SEC_RKEY = SEC_BITS'(32'd1);
    localparam logic [SEC_BITS-1:0] SEC_RMSK = SEC_BITS'(32'd2);
    localparam logic [SEC_BITS-1:0] SEC_RRTE = SEC_BITS'(32'd3);
    localparam logic [SEC_BITS-1:0] SEC_CTR  = SEC_BITS'(32'd4);
    localparam logic [SEC_BITS-1:0] SEC_MKEY = SEC_BITS'(32'd5);
    localparam logic [SEC_BITS-1:0] SEC_FMSK = SEC_BITS'(32'd6);
    localparam logic [SEC_BITS-1:0] SEC_FSFT = SEC_BITS'(32'd7);

    localparam logic [REG_BITS-1:0] REG_STOP   = REG_BITS'(32'd0);
    localparam logic [REG_BITS-1:0] REG_RKEY   = REG_BITS'(32'd1);
    localparam logic [REG_BITS-1:0] REG_IWAIT  = REG_BITS'(32'd2);
    localparam logic [REG_BITS-1:0] REG_OWAIT  = REG_BITS'(32'd3);
    localparam logic [REG_BITS-1:0] REG_STATUS = REG_BITS'(32'd14);
    localparam logic [REG_BITS-1:0] REG_HWVER  = REG_BITS'(32'd15);

`ifdef SPIF_CTR_CLR_ON_RD_EN
    localparam logic CLR_ON_RD = 1'b1;
`else
    localparam logic CLR_ON_RD = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_APB_DONE = 2'd1,
        ST_PRX_RSP  = 2'd2
    } state_t;

    function automatic logic [31:0] sext_fsft(input logic [MSFT_BITS-1:0] v);
        return {{(32-MSFT_BITS){v[MSFT_BITS-1]}}, v};
    endfunction

    state_t               state_r;
    logic                 prx_rdy_r, rsp_vld_r, pready_r, pslverr_r;
    logic [31:0]          rsp_data_r, prdata_r;
    logic                 stop_r;
    logic [31:0]          reply_key_r, in_wait_r, out_wait_r;
    logic [31:0]          rt_key_r   [NUM_RREGS];
    logic [31:0]          rt_mask_r  [NUM_RREGS];
    logic [RRTE_BITS-1:0] rt_route_r [NUM_RREGS];
    logic [31:0]          mp_key_r   [NUM_PIPES];
    logic [31:0]          mp_fmsk_r  [NUM_MREGS];
    logic [MSFT_BITS-1:0] mp_fsft_r  [NUM_MREGS];
    logic [31:0]          ctr_r      [NUM_CREGS];

    logic                 prx_go_s, apb_go_s, exec_s, acc_wr_s, bad_s;
    logic                 wr_en_s, ctr_hit_s;
    logic [SEC_BITS-1:0]  acc_sec_s;
    logic [REG_BITS-1:0]  acc_reg_s;
    logic [31:0]          acc_idx_s, acc_wdata_s, rd_data_s;
    logic [31:0]          rkey_s, rmsk_s, rrte_s, mkey_s, fmsk_s, fsft_s, ctr_s;
    logic                 unused_ok_s;

    assign unused_ok_s = ^{apb_paddr_in[39:REG_BITS+SEC_BITS+2], apb_paddr_in[1:0]};

    // Arbitration: packet port has priority, APB only executes when no packet request
    always_comb begin
        prx_go_s = (state_r == ST_IDLE) & prx_req_in;
        apb_go_s = (state_r == ST_IDLE) & ~prx_req_in & apb_psel_in & apb_penable_in;
        exec_s   = prx_go_s | apb_go_s;
        if (prx_req_in) begin
            acc_wr_s    = prx_wr_in;
            acc_sec_s   = prx_addr_in[REG_BITS +: SEC_BITS];
            acc_reg_s   = prx_addr_in[0 +: REG_BITS];
            acc_wdata_s = prx_wdata_in;
        end else begin
            acc_wr_s    = apb_pwrite_in;
            acc_sec_s   = apb_paddr_in[REG_BITS+2 +: SEC_BITS];
            acc_reg_s   = apb_paddr_in[2 +: REG_BITS];
            acc_wdata_s = apb_pwdata_in;
        end
        acc_idx_s = 32'(acc_reg_s);
    end

    // Address decode: unmapped section, out-of-range index or write to a read-only word
    always_comb begin
        bad_s = 1'b1;
        case (acc_sec_s)
            SEC_CTRL: begin
                if (acc_reg_s == REG_STOP || acc_reg_s == REG_RKEY ||
                    acc_reg_s == REG_IWAIT || acc_reg_s == REG_OWAIT) begin
                    bad_s = 1'b0;
                end else if (acc_reg_s == REG_STATUS || acc_reg_s == REG_HWVER) begin
                    bad_s = acc_wr_s;
                end else begin
                    bad_s = 1'b1;
                end
            end
            SEC_RKEY, SEC_RMSK, SEC_RRTE: bad_s = (acc_idx_s >= N_RREGS_W);
            SEC_CTR:                      bad_s = (acc_idx_s >= N_CREGS_W);
            SEC_MKEY:                     bad_s = (acc_idx_s >= N_PIPES_W);
            SEC_FMSK, SEC_FSFT:           bad_s = (acc_idx_s >= N_MREGS_W);
            default:                      bad_s = 1'b1;
        endcase
        wr_en_s   = exec_s & acc_wr_s & ~bad_s;
        ctr_hit_s = exec_s & ~bad_s & (acc_sec_s == SEC_CTR);
    end

    // Read data mux; per-array selection by index scan keeps odd array sizes safe
    always_comb begin
        rkey_s = 32'd0; rmsk_s = 32'd0; rrte_s = 32'd0; mkey_s = 32'd0;
        fmsk_s = 32'd0; fsft_s = 32'd0; ctr_s = 32'd0;
        for (int i = 0; i < NUM_RREGS; i++) begin
            rkey_s = (acc_idx_s == i) ? rt_key_r[i] : rkey_s;
            rmsk_s = (acc_idx_s == i) ? rt_mask_r[i] : rmsk_s;
            rrte_s = (acc_idx_s == i) ? {{(32-RRTE_BITS){1'b0}}, rt_route_r[i]} : rrte_s;
        end
        for (int i = 0; i < NUM_PIPES; i++) begin
            mkey_s = (acc_idx_s == i) ? mp_key_r[i] : mkey_s;
        end
        for (int i = 0; i < NUM_MREGS; i++) begin
            fmsk_s = (acc_idx_s == i) ? mp_fmsk_r[i] : fmsk_s;
            fsft_s = (acc_idx_s == i) ? sext_fsft(mp_fsft_r[i]) : fsft_s;
        end
        for (int i = 0; i < NUM_CREGS; i++) begin
            ctr_s = (acc_idx_s == i) ? ctr_r[i] : ctr_s;
        end
        rd_data_s = BAD_DATA;
        if (!bad_s) begin
            case (acc_sec_s)
                SEC_CTRL: begin
                    case (acc_reg_s)
                        REG_STOP:   rd_data_s = {31'd0, stop_r};
                        REG_RKEY:   rd_data_s = reply_key_r;
                        REG_IWAIT:  rd_data_s = in_wait_r;
                        REG_OWAIT:  rd_data_s = out_wait_r;
                        REG_STATUS: rd_data_s = status_in;
                        REG_HWVER:  rd_data_s = hw_version_in;
                        default:    rd_data_s = BAD_DATA;
                    endcase
                end
                SEC_RKEY: rd_data_s = rkey_s;
                SEC_RMSK: rd_data_s = rmsk_s;
                SEC_RRTE: rd_data_s = rrte_s;
                SEC_CTR:  rd_data_s = ctr_s;
                SEC_MKEY: rd_data_s = mkey_s;
                SEC_FMSK: rd_data_s = fmsk_s;
                SEC_FSFT: rd_data_s = fsft_s;
                default:  rd_data_s = BAD_DATA;
            endcase
        end else begin
            rd_data_s = BAD_DATA;
        end
    end

    // Access engine with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            prx_rdy_r  <= 1'b1;
            rsp_vld_r  <= 1'b0;
            rsp_data_r <= 32'd0;
            prdata_r   <= 32'd0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (prx_go_s && !acc_wr_s) begin
                        rsp_data_r <= rd_data_s;
                        rsp_vld_r  <= 1'b1;
                        prx_rdy_r  <= 1'b0;
                        state_r    <= ST_PRX_RSP;
                    end else if (apb_go_s) begin
                        if (!acc_wr_s) begin
                            prdata_r <= rd_data_s;
                        end
                        pready_r  <= 1'b1;
                        pslverr_r <= bad_s;
                        state_r   <= ST_APB_DONE;
                    end
                end
                ST_APB_DONE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                ST_PRX_RSP: begin
                    if (prx_rsp_rdy_in) begin
                        rsp_vld_r <= 1'b0;
                        prx_rdy_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    prx_rdy_r <= 1'b1;
                    rsp_vld_r <= 1'b0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    // Control, router and mapper register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_r      <= 1'b0;
            reply_key_r <= 32'hffff_fd00;
            in_wait_r   <= 32'd32;
            out_wait_r  <= 32'd32;
            for (int i = 0; i < NUM_RREGS; i++) begin
                rt_key_r[i]   <= 32'd0;
                rt_mask_r[i]  <= 32'd0;
                rt_route_r[i] <= '0;
            end
            for (int i = 0; i < NUM_PIPES; i++) mp_key_r[i] <= 32'd0;
            for (int i = 0; i < NUM_MREGS; i++) begin
                mp_fmsk_r[i] <= 32'd0;
                mp_fsft_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            case (acc_sec_s)
                SEC_CTRL: begin
                    case (acc_reg_s)
                        REG_STOP:  stop_r      <= acc_wdata_s[0];
                        REG_RKEY:  reply_key_r <= acc_wdata_s;
                        REG_IWAIT: in_wait_r   <= acc_wdata_s;
                        REG_OWAIT: out_wait_r  <= acc_wdata_s;
                        default:   ;
                    endcase
                end
                SEC_RKEY: for (int i = 0; i < NUM_RREGS; i++) if (acc_idx_s == i) rt_key_r[i] <= acc_wdata_s;
                SEC_RMSK: for (int i = 0; i < NUM_RREGS; i++) if (acc_idx_s == i) rt_mask_r[i] <= acc_wdata_s;
                SEC_RRTE: for (int i = 0; i < NUM_RREGS; i++) if (acc_idx_s == i) rt_route_r[i] <= acc_wdata_s[RRTE_BITS-1:0];
                SEC_MKEY: for (int i = 0; i < NUM_PIPES; i++) if (acc_idx_s == i) mp_key_r[i] <= acc_wdata_s;
                SEC_FMSK: for (int i = 0; i < NUM_MREGS; i++) if (acc_idx_s == i) mp_fmsk_r[i] <= acc_wdata_s;
                SEC_FSFT: for (int i = 0; i < NUM_MREGS; i++) if (acc_idx_s == i) mp_fsft_r[i] <= acc_wdata_s[MSFT_BITS-1:0];
                default:  ;
            endcase
        end
    end

    // Diagnostic counters: write beats clear-on-read, which beats increment
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CREGS; i++) ctr_r[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_CREGS; i++) begin
                if (ctr_hit_s && acc_wr_s && acc_idx_s == i) begin
                    ctr_r[i] <= acc_wdata_s;
                end else if (CLR_ON_RD && ctr_hit_s && acc_idx_s == i) begin
                    ctr_r[i] <= {31'd0, ctr_cnt_in[i]};
                end else if (ctr_cnt_in[i]) begin
                    ctr_r[i] <= ctr_r[i] + 32'd1;
                end
            end
        end
    end

    assign apb_prdata_out   = prdata_r;
    assign apb_pready_out   = pready_r;
    assign apb_pslverr_out  = pslverr_r;
    assign prx_rdy_out      = prx_rdy_r;
    assign prx_rsp_vld_out  = rsp_vld_r;
    assign prx_rsp_data_out = rsp_data_r;
    assign hssl_stop_out    = stop_r;
    assign reply_key_out    = reply_key_r;
    assign input_wait_out   = in_wait_r;
    assign output_wait_out  = out_wait_r;
    assign rt_key_out       = rt_key_r;
    assign rt_mask_out      = rt_mask_r;
    assign rt_route_out     = rt_route_r;
    assign mp_key_out       = mp_key_r;
    assign mp_fmsk_out      = mp_fmsk_r;
    assign mp_fsft_out      = mp_fsft_r;
    assign ctr_out          = ctr_r;

endmodule

// File: tb/tb_spif_cfg_reg_bank.sv
// Directed, table-driven bench for spif_cfg_reg_bank (router table shrunk to 12 entries
// so that the out-of-range router index is addressable).
module tb_spif_cfg_reg_bank;
    localparam int NRR = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [39:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        prx_req, prx_wr, prx_rdy, rsp_vld, rsp_rdy;
    logic [7:0]  prx_addr;
    logic [31:0] prx_wdata, rsp_data;
    logic [7:0]  ctr_cnt;
    logic        hssl_stop;
    logic [31:0] reply_key, in_wait, out_wait;
    logic [31:0] rt_key [NRR];
    logic [31:0] rt_mask [NRR];
    logic [2:0]  rt_route [NRR];
    logic [31:0] mp_key [1];
    logic [31:0] mp_fmsk [4];
    logic [5:0]  mp_fsft [4];
    logic [31:0] ctr [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spif_cfg_reg_bank #(.NUM_RREGS(NRR)) dut (
        .clk(clk), .reset(reset),
        .apb_psel_in(psel), .apb_penable_in(penable), .apb_pwrite_in(pwrite),
        .apb_paddr_in(paddr), .apb_pwdata_in(pwdata), .apb_prdata_out(prdata),
        .apb_pready_out(pready), .apb_pslverr_out(pslverr),
        .prx_req_in(prx_req), .prx_wr_in(prx_wr), .prx_addr_in(prx_addr),
        .prx_wdata_in(prx_wdata), .prx_rdy_out(prx_rdy),
        .prx_rsp_vld_out(rsp_vld), .prx_rsp_data_out(rsp_data), .prx_rsp_rdy_in(rsp_rdy),
        .ctr_cnt_in(ctr_cnt), .status_in(32'hcafe_f00d), .hw_version_in(32'h0102_0304),
        .hssl_stop_out(hssl_stop), .reply_key_out(reply_key),
        .input_wait_out(in_wait), .output_wait_out(out_wait),
        .rt_key_out(rt_key), .rt_mask_out(rt_mask), .rt_route_out(rt_route),
        .mp_key_out(mp_key), .mp_fmsk_out(mp_fmsk), .mp_fsft_out(mp_fsft),
        .ctr_out(ctr)
    );

    typedef struct {
        logic        apb;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int cyc);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {30'd0, a, 2'b00}; pwdata = wd;
        cyc = 1;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 2;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (pready) break;
        end
        rd = prdata;
        err = pslverr;
        chk("apb_pready", 32'(pready), 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("apb_pready_drop", 32'(pready), 32'd0);
    endtask

    task automatic prx_issue(input logic wr, input logic [7:0] a, input logic [31:0] wd);
        int k;
        prx_req = 1'b1; prx_wr = wr; prx_addr = a; prx_wdata = wd;
        k = 0;
        while (!prx_rdy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("prx_rdy", 32'(prx_rdy), 32'd1);
        @(posedge clk); #1;
        prx_req = 1'b0;
    endtask

    task automatic prx_rd(input logic [7:0] a, output logic [31:0] d);
        prx_issue(1'b0, a, 32'd0);
        chk("prx_rsp_vld", 32'(rsp_vld), 32'd1);
        d = rsp_data;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          cyc;
        logic [31:0] exp_ctr_after;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 40'd0; pwdata = 32'd0;
        prx_req = 1'b0; prx_wr = 1'b0; prx_addr = 8'd0; prx_wdata = 32'd0; rsp_rdy = 1'b0;
        ctr_cnt = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_prx_rdy", 32'(prx_rdy), 32'd1);
        chk("rst_reply_key", reply_key, 32'hffff_fd00);
        chk("rst_in_wait", in_wait, 32'd32);
        chk("rst_out_wait", out_wait, 32'd32);

        //         apb   wr    addr   wdata          exp            err
        vt.push_back('{1'b1, 1'b0, 8'h00, 32'd0,         32'd0,         1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h01, 32'd0,         32'hffff_fd00, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h02, 32'd0,         32'd32,        1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h03, 32'd0,         32'd32,        1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h0f, 32'd0,         32'h0102_0304, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h0e, 32'd0,         32'hcafe_f00d, 1'b0});
        vt.push_back('{1'b1, 1'b1, 8'h0f, 32'h1234,      32'd0,         1'b1});
        vt.push_back('{1'b1, 1'b1, 8'h0e, 32'h1234,      32'd0,         1'b1});
        vt.push_back('{1'b1, 1'b0, 8'h0f, 32'd0,         32'h0102_0304, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h1c, 32'd0,         32'hdead_0bad, 1'b1});
        vt.push_back('{1'b1, 1'b0, 8'h80, 32'd0,         32'hdead_0bad, 1'b1});
        vt.push_back('{1'b1, 1'b0, 8'h04, 32'd0,         32'hdead_0bad, 1'b1});
        vt.push_back('{1'b1, 1'b1, 8'h24, 32'h0000_ff00, 32'd0,         1'b0});
        vt.push_back('{1'b0, 1'b0, 8'h24, 32'd0,         32'h0000_ff00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 8'h34, 32'hffff_fffd, 32'd0,         1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h34, 32'd0,         32'd5,         1'b0});
        vt.push_back('{1'b0, 1'b1, 8'h72, 32'h0000_003e, 32'd0,         1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h72, 32'd0,         32'hffff_fffe, 1'b0});
        vt.push_back('{1'b0, 1'b0, 8'h74, 32'd0,         32'hdead_0bad, 1'b0});
        vt.push_back('{1'b0, 1'b1, 8'h50, 32'h1234_5678, 32'd0,         1'b0});
        vt.push_back('{1'b0, 1'b0, 8'h51, 32'd0,         32'hdead_0bad, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h50, 32'd0,         32'h1234_5678, 1'b0});
        vt.push_back('{1'b1, 1'b1, 8'h01, 32'haaaa_5555, 32'd0,         1'b0});
        vt.push_back('{1'b1, 1'b1, 8'h00, 32'h0000_0003, 32'd0,         1'b0});
        vt.push_back('{1'b0, 1'b1, 8'h40, 32'h0000_0010, 32'd0,         1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h40, 32'd0,         32'h0000_0010, 1'b0});
        vt.push_back('{1'b1, 1'b0, 8'h48, 32'd0,         32'hdead_0bad, 1'b1});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].apb) begin
                apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, err, cyc);
                chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vt[i].exp_err));
                chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'd3);
                if (!vt[i].wr) chk($sformatf("v%0d_prdata", i), rd, vt[i].exp);
            end else if (vt[i].wr) begin
                prx_issue(1'b1, vt[i].addr, vt[i].wdata);
            end else begin
                prx_rd(vt[i].addr, rd);
                chk($sformatf("v%0d_rsp_data", i), rd, vt[i].exp);
            end
        end

        chk("rt_mask4", rt_mask[4], 32'h0000_ff00);
        chk("rt_key4", rt_key[4], 32'd0);
        chk("rt_route4", 32'(rt_route[4]), 32'd5);
        chk("mp_fsft2", 32'(mp_fsft[2]), 32'h3e);
        chk("mp_key0", mp_key[0], 32'h1234_5678);
        chk("reply_key", reply_key, 32'haaaa_5555);
        chk("hssl_stop", 32'(hssl_stop), 32'd1);

        // Same-cycle APB access phase and packet write to input wait
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {30'd0, 8'h02, 2'b00}; pwdata = 32'd5;
        @(posedge clk); #1;
        penable = 1'b1;
        prx_req = 1'b1; prx_wr = 1'b1; prx_addr = 8'h02; prx_wdata = 32'd7;
        @(posedge clk); #1;
        prx_req = 1'b0;
        chk("arb_prx_first", in_wait, 32'd7);
        chk("arb_apb_wait", 32'(pready), 32'd0);
        @(posedge clk); #1;
        chk("arb_apb_ready", 32'(pready), 32'd1);
        chk("arb_apb_err", 32'(pslverr), 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("arb_final", in_wait, 32'd5);
        chk("arb_pready_drop", 32'(pready), 32'd0);

        // Packet read response stalled for 4 cycles; counter 1 keeps counting meanwhile
        prx_req = 1'b1; prx_wr = 1'b0; prx_addr = 8'h24;
        @(posedge clk); #1;
        prx_req = 1'b0;
        ctr_cnt[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_vld", k), 32'(rsp_vld), 32'd1);
            chk($sformatf("stall%0d_data", k), rsp_data, 32'h0000_ff00);
            chk($sformatf("stall%0d_rdy", k), 32'(prx_rdy), 32'd0);
            @(posedge clk); #1;
        end
        ctr_cnt[1] = 1'b0;
        chk("ctr1_during_rsp", ctr[1], 32'd4);
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk("stall_vld_drop", 32'(rsp_vld), 32'd0);
        chk("stall_rdy_back", 32'(prx_rdy), 32'd1);

        // Counter wrap, then read concurrent with an increment
        prx_issue(1'b1, 8'h40, 32'hffff_ffff);
        chk("ctr0_preset", ctr[0], 32'hffff_ffff);
        ctr_cnt[0] = 1'b1;
        @(posedge clk); #1;
        ctr_cnt[0] = 1'b0;
        chk("ctr0_wrap", ctr[0], 32'd0);
        ctr_cnt[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        prx_req = 1'b1; prx_wr = 1'b0; prx_addr = 8'h40;
        @(posedge clk); #1;
        prx_req = 1'b0; ctr_cnt[0] = 1'b0;
`ifdef SPIF_CTR_CLR_ON_RD_EN
        exp_ctr_after = 32'd1;
`else
        exp_ctr_after = 32'd3;
`endif
        chk("ctr0_rd_vld", 32'(rsp_vld), 32'd1);
        chk("ctr0_rd_data", rsp_data, 32'd2);
        chk("ctr0_after_rd", ctr[0], exp_ctr_after);
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;

        // Reset while a packet response is pending and APB is in access phase
        prx_req = 1'b1; prx_wr = 1'b0; prx_addr = 8'h72;
        @(posedge clk); #1;
        prx_req = 1'b0;
        chk("pre_rst_vld", 32'(rsp_vld), 32'd1);
        chk("pre_rst_data", rsp_data, 32'hffff_fffe);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {30'd0, 8'h02, 2'b00};
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("mid_rst_vld", 32'(rsp_vld), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_pready", 32'(pready), 32'd0);
        chk("mid_rst_prdata", prdata, 32'd0);
        chk("mid_rst_prx_rdy", 32'(prx_rdy), 32'd1);
        chk("mid_rst_fsft2", 32'(mp_fsft[2]), 32'd0);
        chk("mid_rst_rt_mask4", rt_mask[4], 32'd0);
        chk("mid_rst_rt_route4", 32'(rt_route[4]), 32'd0);
        chk("mid_rst_mp_key0", mp_key[0], 32'd0);
        chk("mid_rst_ctr0", ctr[0], 32'd0);
        chk("mid_rst_ctr1", ctr[1], 32'd0);
        chk("mid_rst_stop", 32'(hssl_stop), 32'd0);
        chk("mid_rst_reply_key", reply_key, 32'hffff_fd00);
        chk("mid_rst_in_wait", in_wait, 32'd32);
        chk("mid_rst_out_wait", out_wait, 32'd32);
        @(posedge clk); #1;
        chk("post_rst_pready", 32'(pready), 32'd0);
        apb_xfer(1'b0, 8'h02, 32'd0, rd, err, cyc);
        chk("post_rst_rd", rd, 32'd32);
        chk("post_rst_cycles", 32'(cyc), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
